gate_model_bist: RTL
====================

// Module: gate_model_bist
// PURPOSE
//  Parametrised built-in self-test wrapper for combinational GateModel netlists.
//  An LFSR drives the DUT inputs, and a MISR compacts the DUT outputs into a signature.
//  The signature is compared against a golden value.
//  Sits between the simulator harness and any GateModel instance; replaces hand-written per-netlist stimulus.
// PARAMETERS
//  IN_W       11       DUT input width (>=2)
//  OUT_W      10       DUT output width (<= SIG_W)
//  SIG_W      16       MISR/signature width
//  PATTERNS   256      patterns applied per run (1..2^IN_W-1)
//  DUT_LAT    0        DUT pipeline latency in cycles (0..3)
//  LFSR_TAPS  11'h500  LFSR feedback mask [IN_W-1:0] (x^11+x^9+1)
//  LFSR_SEED  11'h001  LFSR start value; must be nonzero
//  MISR_TAPS  16'h1021 MISR polynomial mask [SIG_W-1:0]
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous reset, active low
//  start         in   1      begin a run (accepted only in IDLE)
//  abort         in   1      cancel a run; return to IDLE, no done pulse
//  expected_sig  in   SIG_W  golden signature
//  dut_in        out  IN_W   registered stimulus to DUT
//  dut_out       in   OUT_W  DUT response
//  busy          out  1      high in RUN and DRAIN
//  done          out  1      one-cycle pulse at end of run
//  pass          out  1      signature==expected_sig; valid from done, held until next start
//  signature     out  SIG_W  MISR contents
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE.
//   - All outputs 0: dut_in, busy, done, pass, signature.
//   - lfsr=0 and count=0.
//  FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches lfsr=LFSR_SEED, count=0, sig=0, pass=0; next state is RUN.
//  RUN: each cycle:
//   - dut_in = lfsr.
//   - lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)}.
//   - count++.
//   - After PATTERNS cycles, go to DRAIN; go straight to DONE if DUT_LAT=0.
//  DRAIN: lasts DUT_LAT cycles; dut_in holds its last value.
//  MISR update on each sampling cycle, i.e. RUN cycles with count>=DUT_LAT, plus all DRAIN cycles:
//   - sig <= ({sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? MISR_TAPS : 0)) ^ zero_ext(dut_out).
//   - Exactly PATTERNS updates occur per run.
//  DONE: lasts one cycle.
//   - done=1 and pass <= (sig==expected_sig).
//   - Next state is IDLE.
//   - done rises PATTERNS+DUT_LAT+1 cycles after the start cycle.
//  Boundaries:
//   - start while busy: ignored.
//   - abort has priority over start and over the phase transition; from RUN/DRAIN it goes to IDLE.
//   - On abort: signature keeps its partial value; pass=0; done stays 0.
//   - start and abort together in IDLE: abort wins; no run starts.
//   - The LFSR never reaches 0 (SEED nonzero); PATTERNS>period simply repeats the sequence.
//   - rst_n asserted mid-run: immediate return to reset values; no done pulse.
// CONFIGURATION
//  GATE_BIST_EXHAUSTIVE_EN defined:
//   - The LFSR is replaced by a binary counter starting at 0.
//   - PATTERNS is ignored; 2^IN_W patterns are applied (0 .. 2^IN_W-1, incrementing).
//   - done rises 2^IN_W+DUT_LAT+1 cycles after start.
//  Not defined: LFSR mode exactly as above.
// TESTING
//  1. dut_out tied 0, expected_sig=0, start -> done at cycle 257, pass=1, signature=0.
//  2. DUT_LAT=0, PATTERNS=4, dut_out=1 on first sample only -> signature=16'h0008, done at cycle 5.
//  3. Observe dut_in in RUN with default taps/seed -> 001, 002, 004, 008, 010 ...
//  4. Assert abort at RUN count 10 -> busy=0 next cycle, done never pulses, pass=0.
//     A following start runs a full, correct run.
//  5. rst_n low mid-DRAIN (DUT_LAT=2) -> all outputs 0 immediately.
//     start after reset release works normally.
//  6. GATE_BIST_EXHAUSTIVE_EN, IN_W=3 -> dut_in 0..7.
//     done 9+DUT_LAT cycles after start; signature matches the bench model for a real GateModel.

Source files
------------

// File: rtl/gate_model_bist.sv
// gate_model_bist: BIST wrapper for a combinational/pipelined GateModel netlist.
// A stimulus generator (LFSR, or a binary counter when GATE_BIST_EXHAUSTIVE_EN
// is defined) drives o_dut_in. A MISR compacts i_dut_out into o_signature,
// which is compared against i_expected_sig at the end of the run.
// o_dut_in carries pattern k during run cycle k (count==k), so a response is
// sampled once count has advanced DUT_LAT cycles past its pattern.
module gate_model_bist #(
  parameter int              IN_W      = 11,
  parameter int              OUT_W     = 10,
  parameter int              SIG_W     = 16,
  parameter int              PATTERNS  = 256,
  parameter int              DUT_LAT   = 0,
  parameter logic [IN_W-1:0]  LFSR_TAPS = 'h500,
  parameter logic [IN_W-1:0]  LFSR_SEED = 'h001,
  parameter logic [SIG_W-1:0] MISR_TAPS = 'h1021
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [SIG_W-1:0] i_expected_sig,
  output logic [IN_W-1:0]  o_dut_in,
  input  logic [OUT_W-1:0] i_dut_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [SIG_W-1:0] o_signature
);

`ifdef GATE_BIST_EXHAUSTIVE_EN
  localparam int              NPAT  = 2**IN_W;
  localparam logic [IN_W-1:0] FIRST = '0;
`else
  localparam int              NPAT  = PATTERNS;
  localparam logic [IN_W-1:0] FIRST = LFSR_SEED;
`endif

  // Counter spans run + drain: up to 2^IN_W + 3, fits in IN_W+2 bits.
  localparam int             CW       = IN_W + 2;
  localparam logic [CW-1:0]  LAST_RUN = CW'(NPAT - 1);
  localparam logic [CW-1:0]  LAST_DRN = CW'(NPAT + DUT_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [IN_W-1:0]  r_pat;
  logic [CW-1:0]    r_cnt;
  logic [SIG_W-1:0] r_sig;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             w_sample;
  logic [SIG_W-1:0] w_sig_nxt;

  function automatic logic [IN_W-1:0] step(input logic [IN_W-1:0] x);
`ifdef GATE_BIST_EXHAUSTIVE_EN
    step = x + {{(IN_W-1){1'b0}}, 1'b1};
`else
    step = {x[IN_W-2:0], ^(x & LFSR_TAPS)};
`endif
  endfunction

  // MISR next value: shift with polynomial feedback, fold in the response.
  always_comb begin
    w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? MISR_TAPS : '0)
              ^ SIG_W'(i_dut_out);
    w_sample  = (int'(r_cnt) >= DUT_LAT);
  end

  // Run sequencer: abort outranks start and every phase transition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_cnt   <= '0;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        // Signature keeps its partial value; an IDLE abort only blocks start.
        if (r_state != S_IDLE) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_pass  <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: if (i_start) begin
            r_pat   <= FIRST;
            r_cnt   <= '0;
            r_sig   <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
          S_RUN: begin
            r_cnt <= r_cnt + 1'b1;
            if (w_sample) r_sig <= w_sig_nxt;
            if (r_cnt == LAST_RUN) begin
              // Last pattern stays on o_dut_in through the drain.
              if (DUT_LAT == 0) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_DRAIN;
              end
            end else begin
              r_pat <= step(r_pat);
            end
          end
          S_DRAIN: begin
            r_cnt <= r_cnt + 1'b1;
            r_sig <= w_sig_nxt;
            if (r_cnt == LAST_DRN) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_pass  <= (r_sig == i_expected_sig);
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_dut_in    = r_pat;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_signature = r_sig;

endmodule
